// File: rtl/des_pkg.sv
// Shared DES key-schedule constants: PC-1/PC-2 index tables, rotation schedule
// and 28-bit half-register rotate helpers.
package des_pkg;

    localparam int unsigned DES_ROUNDS = 16;
    localparam int unsigned HALF_W     = 28;

    // Table entries are 1-based bit numbers, bit 1 = MSB
    localparam int unsigned PC1_TAB [1:56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int unsigned PC2_TAB [1:48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    localparam logic [1:0] ROT_SCHED [1:16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    typedef enum logic {
        ST_IDLE,
        ST_EMIT
    } state_t;

    typedef logic [1:HALF_W] half_t;

    function automatic half_t rot_left(input half_t x, input logic [1:0] n);
        return (n == 2'd1) ? {x[2:HALF_W], x[1]} : {x[3:HALF_W], x[1:2]};
    endfunction

    function automatic half_t rot_right(input half_t x, input logic [1:0] n);
        return (n == 2'd1) ? {x[HALF_W], x[1:HALF_W-1]}
                           : {x[HALF_W-1:HALF_W], x[1:HALF_W-2]};
    endfunction

endpackage

// File: rtl/des_pc1.sv
// PC-1 permutation: 64-bit raw key (with parity) to 56-bit C||D.
module des_pc1
    import des_pkg::*;
(
    input  logic [1:64] i_key,
    output logic [1:56] o_cd
);

    for (genvar i = 1; i <= 56; i++) begin : g_bit
        assign o_cd[i] = i_key[PC1_TAB[i]];
    end

endmodule

// File: rtl/des_pc2.sv
// PC-2 compression: 56-bit C||D to 48-bit round subkey.
module des_pc2
    import des_pkg::*;
(
    input  logic [1:56] i_cd,
    output logic [1:48] o_subkey
);

    for (genvar i = 1; i <= 48; i++) begin : g_bit
        assign o_subkey[i] = i_cd[PC2_TAB[i]];
    end

endmodule

// File: rtl/des_subkey_sequencer.sv
// DES key-schedule engine: streams the 16 round subkeys over valid/ready in
// encrypt (K1..K16, left rotate) or decrypt (K16..K1, right rotate) order.
module des_subkey_sequencer
    import des_pkg::*;
#(
    parameter bit PARITY_CHECK = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        decrypt,
    input  logic        abort,
    input  logic [1:64] key,
    output logic [1:48] subkey,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic [3:0]  round,
    output logic        last,
    output logic        busy,
    output logic        done,
    output logic        key_parity_err
);

    localparam logic [4:0] LAST_RND = 5'(DES_ROUNDS);

    state_t      r_state,   w_state_nxt;
    half_t       r_c,       w_c_nxt;
    half_t       r_d,       w_d_nxt;
    logic [4:0]  r_round,   w_round_nxt;
    logic        r_decrypt, w_dec_nxt;
    logic        r_done,    w_done_nxt;
    logic        r_perr,    w_perr_nxt;

    logic [1:56] w_pc1_cd;
    logic        w_par_err;
    logic [4:0]  w_rnd_inc;
    logic [1:0]  w_amt;

    des_pc1 u_pc1 (
        .i_key (key),
        .o_cd  (w_pc1_cd)
    );

    des_pc2 u_pc2 (
        .i_cd     ({r_c, r_d}),
        .o_subkey (subkey)
    );

    always_comb begin
        w_par_err = 1'b0;
        for (int unsigned b = 0; b < 8; b++) begin
            if (^key[8*b+1 +: 8] == 1'b0) w_par_err = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_c_nxt     = r_c;
        w_d_nxt     = r_d;
        w_round_nxt = r_round;
        w_dec_nxt   = r_decrypt;
        w_perr_nxt  = r_perr;
        w_done_nxt  = 1'b0;
        w_amt       = 2'd1;
        w_rnd_inc   = r_round + 5'd1;

        if (abort) begin
            w_state_nxt = ST_IDLE;
            w_round_nxt = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        // Decrypt starts from C0D0, which equals C16D16 (rotations sum to 28)
                        w_c_nxt     = decrypt ? w_pc1_cd[1:28]  : rot_left(w_pc1_cd[1:28], 2'd1);
                        w_d_nxt     = decrypt ? w_pc1_cd[29:56] : rot_left(w_pc1_cd[29:56], 2'd1);
                        w_round_nxt = 5'd1;
                        w_dec_nxt   = decrypt;
                        w_perr_nxt  = PARITY_CHECK ? w_par_err : 1'b0;
                        w_state_nxt = ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (subkey_ready) begin
                        if (r_round == LAST_RND) begin
                            w_state_nxt = ST_IDLE;
                            w_round_nxt = '0;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_amt       = ROT_SCHED[w_rnd_inc];
                            w_round_nxt = w_rnd_inc;
                            w_c_nxt     = r_decrypt ? rot_right(r_c, w_amt) : rot_left(r_c, w_amt);
                            w_d_nxt     = r_decrypt ? rot_right(r_d, w_amt) : rot_left(r_d, w_amt);
                        end
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_c       <= '0;
            r_d       <= '0;
            r_round   <= '0;
            r_decrypt <= 1'b0;
            r_done    <= 1'b0;
            r_perr    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_c       <= w_c_nxt;
            r_d       <= w_d_nxt;
            r_round   <= w_round_nxt;
            r_decrypt <= w_dec_nxt;
            r_done    <= w_done_nxt;
            r_perr    <= w_perr_nxt;
        end
    end

    // The 4-bit round port wraps position 16 to 0; last marks that position
    assign round          = r_round[3:0];
    assign subkey_valid   = (r_state == ST_EMIT);
    assign busy           = (r_state == ST_EMIT);
    assign last           = (r_state == ST_EMIT) && (r_round == LAST_RND);
    assign done           = r_done;
    assign key_parity_err = r_perr;

endmodule
